// File: rtl/demux_reg_1xn.sv
// demux_reg_1xn: routes one input word to one of N_OUT channels and holds it there for HOLD_CYC cycles.
// Latency: a word accepted on edge e appears on its channel from e+1 for exactly HOLD_CYC cycles.
// Backpressure: ready is high only in IDLE, and requests made while busy are dropped, not queued.
//
// Ports:
//   clk, rst_n        - system clock; synchronous active-low reset
//   in, in_valid, S   - data word, request strobe, channel selector
//   ready             - high while idle (a request this cycle is taken)
//   Out, out_valid    - concatenated channel data (channel k at [k*DATA_W +: DATA_W]); one-hot valid
//   err               - one-cycle pulse after a request with S >= N_OUT
//   abort             - present only when DEMUX_ABORT_EN is defined; ends the current hold early
//
// Optional feature macro: DEMUX_ABORT_EN

module demux_reg_1xn #(
    parameter int N_OUT    = 7,
    parameter int DATA_W   = 1,
    parameter int HOLD_CYC = 4,
    localparam int SEL_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in,
    input  logic                      in_valid,
    input  logic [SEL_W-1:0]          S,
`ifdef DEMUX_ABORT_EN
    input  logic                      abort,
`endif
    output logic                      ready,
    output logic [N_OUT*DATA_W-1:0]   Out,
    output logic [N_OUT-1:0]          out_valid,
    output logic                      err
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Counter is loaded with HOLD_CYC-1 so that the exit edge is the one
    // where it already reads zero, giving exactly HOLD_CYC hold cycles.
    localparam logic [7:0]       CNT_LOAD = 8'(HOLD_CYC - 1);
    // One extra bit so that S can be compared against N_OUT even when
    // N_OUT is a power of two (e.g. 16 with a 4-bit selector).
    localparam logic [SEL_W:0]   N_OUT_CMP = (SEL_W + 1)'(N_OUT);

    state_t                    r_state;
    logic [7:0]                r_cnt;
    logic [SEL_W-1:0]          r_sel;
    logic [DATA_W-1:0]         r_dat;
    logic                      r_err;

    logic                      w_in_range;
    logic                      w_abort;
    logic [N_OUT-1:0]          w_vld;
    logic [N_OUT*DATA_W-1:0]   w_out;

    assign w_in_range = ({1'b0, S} < N_OUT_CMP);

`ifdef DEMUX_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Output decode from registered state only: in IDLE everything reads 0,
    // so leaving HOLD clears the channel without touching the latched word.
    always_comb begin
        w_vld = '0;
        w_out = '0;
        if (r_state == HOLD) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (r_sel == SEL_W'(k)) begin
                    w_vld[k]                    = 1'b1;
                    w_out[k*DATA_W +: DATA_W]   = r_dat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_in_range) begin
                            r_sel   <= S;
                            r_dat   <= in;
                            r_cnt   <= CNT_LOAD;
                            r_state <= HOLD;
                        end else begin
                            // Bad selector: flag it, stay idle, outputs untouched.
                            r_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_abort || (r_cnt == 8'd0)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (r_state == IDLE);
    assign Out       = w_out;
    assign out_valid = w_vld;
    assign err       = r_err;

endmodule
